// File: rtl/frame_sequencer.sv
// Frame sequencer: divides the system clock to frame events and walks the 8-step APU sequence.
// Latency: strobes, step and len_next_odd update on the clk edge where the event is seen (1 clk after evt).
// Backpressure: none; downstream units must consume each single-cycle strobe when it is high.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   apu_on          master enable level; low freezes the block at step 0
//   div_reset       one-cycle DIV write pulse; clears the prescaler (internal mode only)
//   ext_div_bit     DIV-APU bit, already synchronous to clk; falling edge = event (USE_EXT=1)
//   frame_tick      pulse on every frame event
//   length_tick     pulse on steps 0,2,4,6
//   sweep_tick      pulse on steps 2,6
//   env_tick        pulse on step 7
//   step            next step to execute
//   len_next_odd    step[0]; high means the next event will not clock length
module frame_sequencer #(
   parameter int DIVIDER = 8192,
   parameter int DIV_W   = 13,
   parameter bit USE_EXT = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       apu_on,
   input  logic       div_reset,
   input  logic       ext_div_bit,
   output logic       frame_tick,
   output logic       length_tick,
   output logic       sweep_tick,
   output logic       env_tick,
   output logic [2:0] step,
   output logic       len_next_odd
);

   localparam logic [DIV_W-1:0] LP_LAST = DIV_W'(DIVIDER - 1);

   logic [DIV_W-1:0] r_presc;
   logic [2:0]       r_step;
   logic             r_ext_q;
   logic             r_frame;
   logic             r_len;
   logic             r_sweep;
   logic             r_env;

   logic             w_presc_last;
   logic             w_evt_int;
   logic             w_evt_ext;
   logic             w_evt;

   assign w_presc_last = (r_presc == LP_LAST);

   // A DIV write landing on the terminal count swallows that event.
   assign w_evt_int = apu_on & ~div_reset & w_presc_last;

   // Falling edge of the DIV-APU bit.
   assign w_evt_ext = apu_on & r_ext_q & ~ext_div_bit;

   assign w_evt = USE_EXT ? w_evt_ext : w_evt_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_step  <= '0;
         r_ext_q <= 1'b0;
         r_frame <= 1'b0;
         r_len   <= 1'b0;
         r_sweep <= 1'b0;
         r_env   <= 1'b0;
      end else begin
         // Edge history is kept even while disabled so a re-enable does not see a stale level.
         r_ext_q <= ext_div_bit;
         if (!apu_on) begin
            r_presc <= '0;
            r_step  <= '0;
            r_frame <= 1'b0;
            r_len   <= 1'b0;
            r_sweep <= 1'b0;
            r_env   <= 1'b0;
         end else begin
            // In external mode the prescaler is parked at zero.
            if (USE_EXT || div_reset || w_presc_last) begin
               r_presc <= '0;
            end else begin
               r_presc <= r_presc + DIV_W'(1);
            end
            // Strobes are decoded from the step being executed, not the one that follows.
            r_frame <= w_evt;
            r_len   <= w_evt & ~r_step[0];
            r_sweep <= w_evt & ((r_step == 3'd2) | (r_step == 3'd6));
            r_env   <= w_evt & (r_step == 3'd7);
            if (w_evt) begin
               r_step <= r_step + 3'd1;
            end
         end
      end
   end

   assign frame_tick   = r_frame;
   assign length_tick  = r_len;
   assign sweep_tick   = r_sweep;
   assign env_tick     = r_env;
   assign step         = r_step;
   assign len_next_odd = r_step[0];

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: one internal-prescaler instance (DIVIDER=16) and one
// external-edge instance share stimulus; both are compared every cycle to a reference model
// that schedules frame events by absolute cycle number and derives strobes from the event count.
module tb_frame_sequencer;

   localparam int D = 16;

   logic       clk;
   logic       rst_n;
   logic       apu_on;
   logic       div_reset;
   logic       ext_div_bit;

   logic       frm_i, len_i, swp_i, env_i, odd_i;
   logic [2:0] stp_i;
   logic       frm_e, len_e, swp_e, env_e, odd_e;
   logic [2:0] stp_e;

   int checks   = 0;
   int failures = 0;

   frame_sequencer #(.DIVIDER(D), .DIV_W(4), .USE_EXT(1'b0)) u_int (
      .clk(clk), .rst_n(rst_n), .apu_on(apu_on), .div_reset(div_reset),
      .ext_div_bit(ext_div_bit),
      .frame_tick(frm_i), .length_tick(len_i), .sweep_tick(swp_i), .env_tick(env_i),
      .step(stp_i), .len_next_odd(odd_i)
   );

   frame_sequencer #(.DIVIDER(D), .DIV_W(4), .USE_EXT(1'b1)) u_ext (
      .clk(clk), .rst_n(rst_n), .apu_on(apu_on), .div_reset(div_reset),
      .ext_div_bit(ext_div_bit),
      .frame_tick(frm_e), .length_tick(len_e), .sweep_tick(swp_e), .env_tick(env_e),
      .step(stp_e), .len_next_odd(odd_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. Index 0 = internal instance, 1 = external instance.
   int  cyc;          // number of clk edges so far
   int  m_next;       // edge number at which the next internal event launches its strobes
   int  m_step [2];   // step that the next event will execute
   bit  m_frm  [2];
   bit  m_len  [2];
   bit  m_swp  [2];
   bit  m_env  [2];
   bit  m_extp;       // ext_div_bit as seen at the previous edge
   bit  sq_mode;
   int  sq_cnt;

   task automatic model_clear(input int i);
      m_frm[i] = 0; m_len[i] = 0; m_swp[i] = 0; m_env[i] = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_step[i] = 0;
         model_clear(i);
      end
      m_extp = 0;
   endtask

   task automatic model_event(input int i);
      int s;
      s = m_step[i];
      m_frm[i] = 1;
      m_len[i] = (s % 2 == 0);
      m_swp[i] = (s == 2) || (s == 6);
      m_env[i] = (s == 7);
      m_step[i] = (s + 1) % 8;
   endtask

   // Advance the model across the coming edge using the inputs as they stand now.
   task automatic model_edge();
      int  e;
      bit  evt;
      e = cyc + 1;
      if (!rst_n) begin
         model_reset();
         m_next = e + D;
      end else begin
         if (!apu_on) begin
            m_step[0] = 0;
            model_clear(0);
            m_next = e + D;
         end else if (div_reset) begin
            model_clear(0);
            m_next = e + D;
         end else if (e == m_next) begin
            model_event(0);
            m_next = e + D;
         end else begin
            model_clear(0);
         end
         evt = apu_on && m_extp && !ext_div_bit;
         m_extp = ext_div_bit;
         if (!apu_on) begin
            m_step[1] = 0;
            model_clear(1);
         end else if (evt) begin
            model_event(1);
         end else begin
            model_clear(1);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic compare_all();
      chk("int_frame", 32'(frm_i), 32'(m_frm[0]));
      chk("int_len",   32'(len_i), 32'(m_len[0]));
      chk("int_sweep", 32'(swp_i), 32'(m_swp[0]));
      chk("int_env",   32'(env_i), 32'(m_env[0]));
      chk("int_step",  32'(stp_i), 32'(m_step[0]));
      chk("int_odd",   32'(odd_i), 32'(m_step[0] % 2));
      chk("ext_frame", 32'(frm_e), 32'(m_frm[1]));
      chk("ext_len",   32'(len_e), 32'(m_len[1]));
      chk("ext_sweep", 32'(swp_e), 32'(m_swp[1]));
      chk("ext_env",   32'(env_e), 32'(m_env[1]));
      chk("ext_step",  32'(stp_e), 32'(m_step[1]));
      chk("ext_odd",   32'(odd_e), 32'(m_step[1] % 2));
   endtask

   // One clock: optional square-wave drive, model update, edge, sample 1 time unit later.
   task automatic cyc1();
      if (sq_mode) begin
         ext_div_bit = ((sq_cnt / 16) % 2) != 0;
         sq_cnt++;
      end
      model_edge();
      @(posedge clk);
      cyc++;
      #1;
      compare_all();
   endtask

   initial begin
      int n_len, n_swp, n_env, n_ext, n_frm, wait_n, saved, first;

      rst_n = 1'b0; apu_on = 1'b1; div_reset = 1'b0; ext_div_bit = 1'b0;
      cyc = 0; m_next = D; sq_mode = 1'b0; sq_cnt = 0;
      model_reset();

      // Reset state
      #1;
      compare_all();
      for (int i = 0; i < 3; i++) cyc1();

      // 1: release reset with apu_on high; first tick 16 clks later, 8 events
      rst_n = 1'b1;
      sq_mode = 1'b1;
      first = -1;
      for (int i = 1; i <= 8 * D; i++) begin
         cyc1();
         if (frm_i && first < 0) first = i;
      end
      chk("t1_first_tick", 32'(first), 32'(16));
      chk("t1_step_after_8", 32'(stp_i), 32'(0));

      // 2: 16 more events; pulse totals
      n_len = 0; n_swp = 0; n_env = 0; n_frm = 0;
      for (int i = 0; i < 16 * D; i++) begin
         cyc1();
         n_len += int'(len_i); n_swp += int'(swp_i); n_env += int'(env_i); n_frm += int'(frm_i);
      end
      chk("t2_frames", 32'(n_frm), 32'(16));
      chk("t2_len_cnt", 32'(n_len), 32'(8));
      chk("t2_sweep_cnt", 32'(n_swp), 32'(4));
      chk("t2_env_cnt", 32'(n_env), 32'(2));

      // 3: div_reset with prescaler at 10, then at 15
      wait_n = 0;
      while ((m_next - cyc) != 6 && wait_n < 64) begin cyc1(); wait_n++; end
      saved = m_step[0];
      div_reset = 1'b1;
      cyc1();
      div_reset = 1'b0;
      chk("t3_step_hold", 32'(stp_i), 32'(saved));
      wait_n = 0;
      do begin cyc1(); wait_n++; end while (!frm_i && wait_n < 40);
      chk("t3_tick_after_divrst", 32'(wait_n), 32'(16));
      wait_n = 0;
      while ((m_next - cyc) != 1 && wait_n < 64) begin cyc1(); wait_n++; end
      div_reset = 1'b1;
      cyc1();
      div_reset = 1'b0;
      chk("t3_no_tick_at_last", 32'(frm_i), 32'(0));

      // 4: drop apu_on at step 5 mid-period for 40 clks
      wait_n = 0;
      while (!(m_step[0] == 5 && (m_next - cyc) == 8) && wait_n < 400) begin cyc1(); wait_n++; end
      apu_on = 1'b0;
      n_frm = 0; n_ext = 0;
      for (int i = 0; i < 40; i++) begin
         cyc1();
         n_frm += int'(frm_i); n_ext += int'(frm_e);
         if (i == 39) chk("t4_step_low", 32'(stp_i), 32'(0));
      end
      chk("t4_int_ticks_low", 32'(n_frm), 32'(0));
      chk("t4_ext_ticks_low", 32'(n_ext), 32'(0));
      apu_on = 1'b1;
      wait_n = 0;
      do begin cyc1(); wait_n++; end while (!frm_i && wait_n < 40);
      chk("t4_tick_after_rise", 32'(wait_n), 32'(16));
      chk("t4_len_on_step0", 32'(len_i), 32'(1));

      // 5: 32-clk square wave on ext_div_bit gives 8 external events per 256 clks
      n_ext = 0;
      for (int i = 0; i < 256; i++) begin cyc1(); n_ext += int'(frm_e); end
      chk("t5_ext_ticks", 32'(n_ext), 32'(8));

      // 6: asynchronous reset while a strobe is high
      wait_n = 0;
      while (!m_frm[0] && wait_n < 40) begin cyc1(); wait_n++; end
      chk("t6_strobe_seen", 32'(frm_i), 32'(1));
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_async_frame", 32'(frm_i), 32'(0));
      chk("t6_async_len", 32'(len_i), 32'(0));
      chk("t6_async_step", 32'(stp_i), 32'(0));
      chk("t6_async_ext_step", 32'(stp_e), 32'(0));
      cyc1();
      rst_n = 1'b1;
      wait_n = 0;
      do begin cyc1(); wait_n++; end while (!frm_i && wait_n < 40);
      chk("t6_resume_delay", 32'(wait_n), 32'(16));
      chk("t6_resume_len", 32'(len_i), 32'(1));

      // Random phase: sporadic DIV writes, enable drops and arbitrary ext_div_bit activity
      sq_mode = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         div_reset = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 149) == 0) apu_on = ~apu_on;
         if ($urandom_range(0, 5) == 0) ext_div_bit = ~ext_div_bit;
         cyc1();
      end
      apu_on = 1'b1;
      div_reset = 1'b0;
      for (int i = 0; i < 64; i++) cyc1();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
